// File: rtl/axis_xbar_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin crossbar.
// Holds the per-input state encoding and small sizing functions.
package axis_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DROP
  } in_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic dest_ok(
    input int unsigned d,
    input int unsigned n
  );
    return d < n;
  endfunction

endpackage

// File: rtl/axis_crossbar_rr_rr_arbiter.sv
// Per-output round-robin arbiter with a registered one-hot grant.
// A grant is held until released, then the output idles one cycle.
module rr_arbiter
  import axis_xbar_pkg::*;
#(
  parameter int P_N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [P_N-1:0] i_req,
  input  logic           i_release,
  output logic [P_N-1:0] o_grant
);

  localparam int IW = clog2(P_N);

  logic [P_N-1:0] r_grant;
  logic [IW-1:0]  r_last;
  logic [P_N-1:0] w_pick;
  logic [IW-1:0]  w_idx;
  logic [IW-1:0]  w_j;
  logic           w_found;

  // search requesters starting just after the last granted input
  always_comb begin
    w_pick  = '0;
    w_idx   = r_last;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < P_N; k++) begin
      w_j = IW'((int'(r_last) + 1 + k) % P_N);
      if (!w_found && i_req[w_j]) begin
        w_found     = 1'b1;
        w_pick[w_j] = 1'b1;
        w_idx       = w_j;
      end
    end
  end

  // hold grant until release; only grant while the output is unowned
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_grant <= '0;
      r_last  <= IW'(P_N - 1);
    end else if (|r_grant) begin
      if (i_release) r_grant <= '0;
    end else if (w_found) begin
      r_grant <= w_pick;
      r_last  <= w_idx;
    end
  end

  assign o_grant = r_grant;

endmodule

// File: rtl/axis_crossbar_rr.sv
// N x N AXI-Stream packet crossbar, round-robin per output.
// Packets route atomically by tdest; out-of-range tdest is dropped.
module axis_crossbar_rr
  import axis_xbar_pkg::*;
#(
  parameter int P_CROSSBAR_N = 4,
  parameter int P_DATA_W     = 64,
  parameter int P_DEST_W     = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [P_CROSSBAR_N-1:0]             s_axis_rx_tvalid,
  input  logic [P_CROSSBAR_N*P_DATA_W-1:0]    s_axis_rx_tdata,
  input  logic [P_CROSSBAR_N*P_DATA_W/8-1:0]  s_axis_rx_tkeep,
  input  logic [P_CROSSBAR_N-1:0]             s_axis_rx_tlast,
  input  logic [P_CROSSBAR_N-1:0]             s_axis_rx_tuser,
  input  logic [P_CROSSBAR_N*P_DEST_W-1:0]    s_axis_rx_tdest,
  output logic [P_CROSSBAR_N-1:0]             s_axis_rx_tready,
  output logic [P_CROSSBAR_N-1:0]             m_axis_tx_tvalid,
  output logic [P_CROSSBAR_N*P_DATA_W-1:0]    m_axis_tx_tdata,
  output logic [P_CROSSBAR_N*P_DATA_W/8-1:0]  m_axis_tx_tkeep,
  output logic [P_CROSSBAR_N-1:0]             m_axis_tx_tlast,
  output logic [P_CROSSBAR_N-1:0]             m_axis_tx_tuser,
  input  logic [P_CROSSBAR_N-1:0]             m_axis_tx_tready,
  output logic [P_CROSSBAR_N-1:0]             o_drop
);

  localparam int N = P_CROSSBAR_N;
  localparam int W = P_DATA_W;
  localparam int K = P_DATA_W / 8;
  localparam int D = P_DEST_W;

  in_state_e      r_state [N];
  in_state_e      w_nxt   [N];
  logic [D-1:0]   r_dest  [N];
  logic [D-1:0]   w_dest  [N];
  logic [N-1:0]   r_drop;

  logic [N-1:0]   w_gnt [N];
  logic [N-1:0]   w_req [N];
  logic [N-1:0]   w_rel;
  logic [N-1:0]   w_ld;
  logic [W-1:0]   w_md [N];
  logic [K-1:0]   w_mk [N];
  logic [N-1:0]   w_ml;
  logic [N-1:0]   w_mu;

  logic [N-1:0]   w_own;
  logic [N-1:0]   w_rdy;
  logic [N-1:0]   w_drp;
  logic [N-1:0]   w_bad;
  logic [N-1:0]   w_ask;
  logic [N-1:0]   w_acc;
  logic [N-1:0]   w_fin;

  logic [N-1:0]   r_tvalid;
  logic [N*W-1:0] r_tdata;
  logic [N*K-1:0] r_tkeep;
  logic [N-1:0]   r_tlast;
  logic [N-1:0]   r_tuser;

  // head-beat destination and request qualification per input
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dest[i] = (r_state[i] == ST_IDLE) ?
                  s_axis_rx_tdest[i*D +: D] : r_dest[i];
      w_bad[i]  = !dest_ok(32'(w_dest[i]), 32'(N));
      w_drp[i]  = (r_state[i] == ST_DROP);
      w_ask[i]  = s_axis_rx_tvalid[i] && !w_bad[i] && !w_own[i] &&
                  (r_state[i] == ST_IDLE || r_state[i] == ST_REQ);
    end
  end

  // ownership and ready: owner may load when the output slot frees
  always_comb begin
    w_own = '0;
    w_rdy = '0;
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < N; o++) begin
        if (w_gnt[o][i]) begin
          w_own[i] = 1'b1;
          w_rdy[i] = !r_tvalid[o] || m_axis_tx_tready[o];
        end
      end
    end
  end

  assign s_axis_rx_tready = w_rdy | w_drp;
  assign w_acc = s_axis_rx_tvalid & s_axis_rx_tready;
  assign w_fin = w_acc & s_axis_rx_tlast;

  // per-output request vectors, load strobes and owner data mux
  always_comb begin
    for (int o = 0; o < N; o++) begin
      w_ld[o]  = |(w_gnt[o] & w_acc);
      w_rel[o] = |(w_gnt[o] & w_fin);
      w_md[o]  = '0;
      w_mk[o]  = '0;
      w_ml[o]  = 1'b0;
      w_mu[o]  = 1'b0;
      w_req[o] = '0;
      for (int i = 0; i < N; i++) begin
        w_req[o][i] = w_ask[i] && (w_dest[i] == D'(o));
        if (w_gnt[o][i]) begin
          w_md[o] = s_axis_rx_tdata[i*W +: W];
          w_mk[o] = s_axis_rx_tkeep[i*K +: K];
          w_ml[o] = s_axis_rx_tlast[i];
          w_mu[o] = s_axis_rx_tuser[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_arb
    rr_arbiter #(
      .P_N(N)
    ) u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    (w_req[g]),
      .i_release(w_rel[g]),
      .o_grant  (w_gnt[g])
    );
  end

  // per-input next state
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_nxt[i] = r_state[i];
      unique case (r_state[i])
        ST_IDLE: begin
          if (s_axis_rx_tvalid[i])
            w_nxt[i] = w_bad[i] ? ST_DROP : ST_REQ;
        end
        ST_REQ: begin
          if (w_fin[i])      w_nxt[i] = ST_IDLE;
          else if (w_own[i]) w_nxt[i] = ST_XFER;
        end
        ST_XFER: begin
          if (w_fin[i]) w_nxt[i] = ST_IDLE;
        end
        ST_DROP: begin
          if (w_fin[i]) w_nxt[i] = ST_IDLE;
        end
        default: w_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // per-input state, captured head destination, drop pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_drop <= '0;
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_IDLE;
        r_dest[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_nxt[i];
        r_drop[i]  <= w_drp[i] && w_fin[i];
        if (r_state[i] == ST_IDLE)
          r_dest[i] <= s_axis_rx_tdest[i*D +: D];
      end
    end
  end

  // one-beat output register per output
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tvalid <= '0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= '0;
      r_tuser  <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        if (w_ld[o]) begin
          r_tvalid[o]       <= 1'b1;
          r_tdata[o*W +: W] <= w_md[o];
          r_tkeep[o*K +: K] <= w_mk[o];
          r_tlast[o]        <= w_ml[o];
          r_tuser[o]        <= w_mu[o];
        end else if (m_axis_tx_tready[o]) begin
          r_tvalid[o] <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tx_tvalid = r_tvalid;
  assign m_axis_tx_tdata  = r_tdata;
  assign m_axis_tx_tkeep  = r_tkeep;
  assign m_axis_tx_tlast  = r_tlast;
  assign m_axis_tx_tuser  = r_tuser;
  assign o_drop           = r_drop;

endmodule

// File: tb/tb_axis_crossbar_rr.sv
// Directed/randomised bench for axis_crossbar_rr (N=4, W=64).
// Expected streams come from a packet-level round-robin model.
module tb_axis_crossbar_rr;

  localparam int N = 4;
  localparam int W = 64;
  localparam int K = W / 8;
  localparam int D = 3;

  typedef struct {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
    logic         user;
    int           cyc;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   s_axis_rx_tvalid;
  logic [N*W-1:0] s_axis_rx_tdata;
  logic [N*K-1:0] s_axis_rx_tkeep;
  logic [N-1:0]   s_axis_rx_tlast;
  logic [N-1:0]   s_axis_rx_tuser;
  logic [N*D-1:0] s_axis_rx_tdest;
  logic [N-1:0]   s_axis_rx_tready;
  logic [N-1:0]   m_axis_tx_tvalid;
  logic [N*W-1:0] m_axis_tx_tdata;
  logic [N*K-1:0] m_axis_tx_tkeep;
  logic [N-1:0]   m_axis_tx_tlast;
  logic [N-1:0]   m_axis_tx_tuser;
  logic [N-1:0]   m_axis_tx_tready;
  logic [N-1:0]   o_drop;

  logic         tv   [N];
  logic         tl   [N];
  logic         tu   [N];
  logic [W-1:0] td   [N];
  logic [K-1:0] tk   [N];
  logic [D-1:0] tdst [N];
  logic [N-1:0] mrdy;

  for (genvar g = 0; g < N; g++) begin : g_pk
    assign s_axis_rx_tvalid[g]        = tv[g];
    assign s_axis_rx_tlast[g]         = tl[g];
    assign s_axis_rx_tuser[g]         = tu[g];
    assign s_axis_rx_tdata[g*W +: W]  = td[g];
    assign s_axis_rx_tkeep[g*K +: K]  = tk[g];
    assign s_axis_rx_tdest[g*D +: D]  = tdst[g];
  end
  assign m_axis_tx_tready = mrdy;

  axis_crossbar_rr #(
    .P_CROSSBAR_N(N),
    .P_DATA_W    (W),
    .P_DEST_W    (D)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .s_axis_rx_tvalid(s_axis_rx_tvalid),
    .s_axis_rx_tdata (s_axis_rx_tdata),
    .s_axis_rx_tkeep (s_axis_rx_tkeep),
    .s_axis_rx_tlast (s_axis_rx_tlast),
    .s_axis_rx_tuser (s_axis_rx_tuser),
    .s_axis_rx_tdest (s_axis_rx_tdest),
    .s_axis_rx_tready(s_axis_rx_tready),
    .m_axis_tx_tvalid(m_axis_tx_tvalid),
    .m_axis_tx_tdata (m_axis_tx_tdata),
    .m_axis_tx_tkeep (m_axis_tx_tkeep),
    .m_axis_tx_tlast (m_axis_tx_tlast),
    .m_axis_tx_tuser (m_axis_tx_tuser),
    .m_axis_tx_tready(m_axis_tx_tready),
    .o_drop          (o_drop)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  beat_t rxq [N][$];
  beat_t mb;
  int    mv_cnt, viol, occ_err, acc0, nr;
  int    drop_cnt [N];
  int    drop_cyc [N];
  logic  occ_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor: record accepted output beats and rule checks
  always @(negedge clk) begin
    for (int o = 0; o < N; o++) begin
      if (m_axis_tx_tvalid[o] && m_axis_tx_tready[o]) begin
        mb.data = m_axis_tx_tdata[o*W +: W];
        mb.keep = m_axis_tx_tkeep[o*K +: K];
        mb.last = m_axis_tx_tlast[o];
        mb.user = m_axis_tx_tuser[o];
        mb.cyc  = cyc;
        rxq[o].push_back(mb);
      end
      if (m_axis_tx_tvalid[o]) mv_cnt++;
      nr = 0;
      for (int i = 0; i < N; i++)
        if (tv[i] && s_axis_rx_tready[i] && tdst[i] == D'(o)) nr++;
      if (nr > 1) viol++;
    end
    for (int i = 0; i < N; i++)
      if (o_drop[i]) begin
        drop_cnt[i]++;
        drop_cyc[i] = cyc;
      end
    if (occ_on && tv[0] && acc0 > 0 && acc0 < 16 &&
        (s_axis_rx_tready[0] !== (!m_axis_tx_tvalid[2] || m_axis_tx_tready[2])))
      occ_err++;
    if (tv[0] && s_axis_rx_tready[0]) acc0++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mkpkt(input int src, input int tag, input int n, output beat_t q[$]);
    beat_t x;
    q = {};
    for (int b = 0; b < n; b++) begin
      x.data        = {$urandom, $urandom};
      x.data[63:56] = 8'(src);
      x.data[55:48] = 8'(tag);
      x.data[47:40] = 8'(b);
      x.last        = (b == n - 1);
      x.keep        = x.last ? 8'hF0 : 8'hFF;
      x.user        = 1'($urandom_range(0, 1));
      x.cyc         = 0;
      q.push_back(x);
    end
  endtask

  task automatic put(input int i, input int dest, input beat_t x);
    tv[i]   = 1'b1;
    td[i]   = x.data;
    tk[i]   = x.keep;
    tl[i]   = x.last;
    tu[i]   = x.user;
    tdst[i] = D'(dest);
  endtask

  // drive one packet, advancing only on a sampled handshake
  task automatic send(input int i, input int dest, input beat_t p[$],
                      input int gb, input int gl);
    logic r;
    logic ok;
    int   n;
    ok = 1'b1;
    for (int b = 0; b < p.size(); b++) begin
      if (b == gb && gl > 0) begin
        tv[i] = 1'b0;
        repeat (gl) @(posedge clk);
        #1;
      end
      put(i, dest, p[b]);
      n = 0;
      r = 1'b0;
      while (!r && n < 500) begin
        @(negedge clk);
        r = s_axis_rx_tready[i];
        @(posedge clk);
        #1;
        n++;
      end
      ok = ok & r;
    end
    tv[i] = 1'b0;
    tl[i] = 1'b0;
    chk($sformatf("in%0d_sent", i), 64'(ok), 64'd1);
  endtask

  // compare an output's recorded beats with an expected stream
  task automatic chk_stream(input int o, input beat_t e[$], input int t_first);
    int c;
    c = t_first;
    chk($sformatf("o%0d_len", o), 64'(rxq[o].size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < rxq[o].size(); k++) begin
      chk($sformatf("o%0d_b%0d_data", o, k), rxq[o][k].data, e[k].data);
      chk($sformatf("o%0d_b%0d_keep", o, k), 64'(rxq[o][k].keep), 64'(e[k].keep));
      chk($sformatf("o%0d_b%0d_last", o, k), 64'(rxq[o][k].last), 64'(e[k].last));
      chk($sformatf("o%0d_b%0d_user", o, k), 64'(rxq[o][k].user), 64'(e[k].user));
      if (t_first >= 0)
        chk($sformatf("o%0d_b%0d_cyc", o, k), 64'(rxq[o][k].cyc), 64'(c));
      c += e[k].last ? 2 : 1;
    end
  endtask

  task automatic clrq();
    for (int o = 0; o < N; o++) rxq[o].delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  beat_t pk [N][$];
  beat_t pa [N][$];
  beat_t pb [N][$];
  beat_t pc[$], pd[$], pe0[$], pe2[$], pf[$], pg[$], ex[$];
  int    rr_last [N];
  int    pend [N];
  int    t0, t1, ptr, j, b;
  logic  r;

  initial begin
    for (int i = 0; i < N; i++) begin
      tv[i] = 1'b0; tl[i] = 1'b0; tu[i] = 1'b0;
      td[i] = '0; tk[i] = '0; tdst[i] = '0;
      drop_cnt[i] = 0; drop_cyc[i] = 0;
      rr_last[i] = N - 1;
    end
    mrdy = '1;
    mv_cnt = 0; viol = 0; occ_err = 0; acc0 = 0;
    rst_n = 1'b0;

    // reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mvalid", 64'(m_axis_tx_tvalid), 64'd0);
    chk("rst_sready", 64'(s_axis_rx_tready), 64'd0);
    chk("rst_drop",   64'(o_drop), 64'd0);
    chk("rst_mdata0", m_axis_tx_tdata[63:0], 64'd0);
    chk("rst_mlast",  64'(m_axis_tx_tlast), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: input i -> output (i+1)%N, all start together
    for (int i = 0; i < N; i++) mkpkt(i, i + 1, 16, pk[i]);
    clrq(); viol = 0;
    t0 = cyc;
    fork
      send(0, 1, pk[0], -1, 0);
      send(1, 2, pk[1], -1, 0);
      send(2, 3, pk[2], -1, 0);
      send(3, 0, pk[3], -1, 0);
    join
    repeat (4) @(posedge clk);
    #1;
    for (int o = 0; o < N; o++) begin
      chk_stream(o, pk[(o + N - 1) % N], t0 + 2);
      rr_last[o] = (o + N - 1) % N;
    end
    chk("t1_viol", 64'(viol), 64'd0);

    // T2: all inputs send two packets to output 0
    for (int i = 0; i < N; i++) begin
      mkpkt(i, 8'h10 + i, 16, pa[i]);
      mkpkt(i, 8'h20 + i, 16, pb[i]);
      pend[i] = 2;
    end
    clrq(); viol = 0;
    ex = {};
    ptr = (rr_last[0] + 1) % N;
    for (int p = 0; p < 2 * N; p++) begin
      j = ptr;
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (pend[j] > 0) break;
      end
      ex = (pend[j] == 2) ? {ex, pa[j]} : {ex, pb[j]};
      pend[j]--;
      rr_last[0] = j;
      ptr = (j + 1) % N;
    end
    t0 = cyc;
    fork
      begin send(0, 0, pa[0], -1, 0); send(0, 0, pb[0], -1, 0); end
      begin send(1, 0, pa[1], -1, 0); send(1, 0, pb[1], -1, 0); end
      begin send(2, 0, pa[2], -1, 0); send(2, 0, pb[2], -1, 0); end
      begin send(3, 0, pa[3], -1, 0); send(3, 0, pb[3], -1, 0); end
    join
    repeat (4) @(posedge clk);
    #1;
    chk_stream(0, ex, t0 + 2);
    chk("t2_viol", 64'(viol), 64'd0);

    // T3: 0 -> 2 with output 2 ready toggling
    mkpkt(0, 8'h30, 16, pc);
    clrq(); occ_err = 0; acc0 = 0; occ_on = 1'b1;
    r = 1'b0;
    fork
      begin send(0, 2, pc, -1, 0); r = 1'b1; end
      begin
        while (!r) begin
          @(posedge clk); #1;
          if (!r) mrdy[2] = ~mrdy[2];
        end
      end
    join
    mrdy = '1;
    repeat (4) @(posedge clk);
    #1;
    occ_on = 1'b0;
    chk_stream(2, pc, -1);
    chk("t3_occ", 64'(occ_err), 64'd0);
    chk("t3_acc", 64'(acc0), 64'd16);

    // T4: bad destination is drained and dropped
    mkpkt(1, 8'h40, 16, pd);
    clrq(); mv_cnt = 0;
    for (int i = 0; i < N; i++) drop_cnt[i] = 0;
    t0 = cyc;
    send(1, 5, pd, -1, 0);
    t1 = cyc;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_cycles", 64'(t1 - t0), 64'd17);
    chk("t4_mvalid", 64'(mv_cnt), 64'd0);
    chk("t4_dropcnt", 64'(drop_cnt[1]), 64'd1);
    chk("t4_dropcyc", 64'(drop_cyc[1]), 64'(t0 + 17));
    chk("t4_drop0", 64'(drop_cnt[0]), 64'd0);

    // T5: input 0 pauses mid-packet while input 2 waits for output 3
    mkpkt(0, 8'h50, 16, pe0);
    mkpkt(2, 8'h52, 16, pe2);
    clrq(); viol = 0;
    fork
      send(0, 3, pe0, 8, 3);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(2, 3, pe2, -1, 0);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    ex = {pe0, pe2};
    chk_stream(3, ex, -1);
    chk("t5_viol", 64'(viol), 64'd0);

    // T6: reset while beat 8 of a 0 -> 1 packet is presented
    mkpkt(0, 8'h60, 16, pf);
    b = 0;
    put(0, 1, pf[0]);
    for (int n = 0; n < 100 && b < 8; n++) begin
      @(negedge clk);
      r = s_axis_rx_tready[0];
      @(posedge clk);
      #1;
      if (r) begin
        b++;
        put(0, 1, pf[b]);
      end
    end
    chk("t6_pre", 64'(b), 64'd8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tv[0] = 1'b0;
    tl[0] = 1'b0;
    @(negedge clk);
    chk("t6_mvalid", 64'(m_axis_tx_tvalid), 64'd0);
    chk("t6_sready", 64'(s_axis_rx_tready), 64'd0);
    @(posedge clk); #1;
    clrq();
    mkpkt(0, 8'h61, 16, pg);
    t0 = cyc;
    send(0, 1, pg, -1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_stream(1, pg, t0 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_crossbar_rr.md
Name: axis_crossbar_rr

Overview:
Parametrised N×N AXI-Stream packet crossbar with per-output round-robin arbitration and full valid/ready backpressure on every port. It replaces the fixed 4-port crossbar in the switch datapath. Packets are routed atomically by tdest: a granted input owns its output from the first beat until tlast. Packets with out-of-range tdest are discarded.

Parameters:
P_CROSSBAR_N, 4, number of input and output ports (2..16)
P_DATA_W, 64, tdata width in bits (multiple of 8)
P_DEST_W, 3, tdest width; must satisfy 2^P_DEST_W >= P_CROSSBAR_N

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active-low
s_axis_rx_tvalid  in  N  per-input valid
s_axis_rx_tdata  in  N*P_DATA_W  input i data at [i*P_DATA_W +: P_DATA_W]
s_axis_rx_tkeep  in  N*P_DATA_W/8  byte enables
s_axis_rx_tlast  in  N  end of packet
s_axis_rx_tuser  in  N  error/user bit, forwarded
s_axis_rx_tdest  in  N*P_DEST_W  destination output index
s_axis_rx_tready  out  N  per-input ready
m_axis_tx_tvalid  out  N  per-output valid
m_axis_tx_tdata  out  N*P_DATA_W  output data
m_axis_tx_tkeep  out  N*P_DATA_W/8  byte enables
m_axis_tx_tlast  out  N  end of packet
m_axis_tx_tuser  out  N  forwarded user bit
m_axis_tx_tready  in  N  per-output ready
o_drop  out  N  one-cycle pulse when input i finishes discarding a bad-dest packet

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all m_axis_tx_* = 0, s_axis_rx_tready = 0, o_drop = 0, all grants cleared, per-input state IDLE, each output's round-robin pointer set so input 0 has top priority.
- Reset mid-packet aborts the packet. Outputs are 0 from the first cycle after the reset edge. No partial-packet recovery is performed.
- Per-input FSM states:
  - IDLE, REQ: input has tvalid with head beat, tdest < N.
  - REQ→XFER: this input receives a grant.
  - XFER→IDLE: the tlast beat is accepted.
  - IDLE→DROP: tvalid with tdest >= N.
  - DROP: tready = 1, beats discarded. On the tlast handshake, o_drop[i] = 1 for one cycle, then IDLE.
- Arbitration per output o:
  - Requesters are inputs in REQ with tdest = o.
  - The grant is registered and decided while the output is unowned, at most one new grant per output per cycle.
  - Priority starts at (last_grant + 1) mod N.
  - The grant holds until the owner's tlast is accepted, then releases in the same cycle. A new grant is registered at the next edge, giving exactly one idle cycle between packets on the same output.
- Datapath: each output has a one-beat output register.
  - s_axis_rx_tready[i] = (i owns o) && (!m_axis_tx_tvalid[o] || m_axis_tx_tready[o]).
  - An accepted beat appears on the output the cycle after acceptance.
  - Output valid clears when tready is high and no new beat is loaded.
- Latency: tvalid raised at cycle 0 with a free output → grant at edge 1 → beat accepted in cycle 1 → m_tvalid at cycle 2. Streaming is one beat per cycle with no bubbles inside a packet.
- tvalid gaps inside a packet: the grant is held and other requesters wait.
- tdest, tkeep and tuser are sampled from every beat. tdest is only acted on at the first beat.
- Inputs to distinct outputs proceed fully in parallel with no mutual stall.

Decomposition:
- Package axis_xbar_pkg: clog2 function, P_IDX_W = clog2(N), input-FSM state encoding (IDLE/REQ/XFER/DROP), helpers for the flattened-vector slices.
- One sub-module, rr_arbiter: an N-request one-hot grant with a rotating pointer and a hold/release input. It is instantiated once per output.

Test Plan:
- N=4, W=64, all m_tready=1. Each input i sends 16 beats (first beat tag i+1) to output (i+1)%4, all starting at the same cycle. Required response:
  - All four outputs show valid 2 cycles later.
  - Beats are contiguous, tags and data are intact, tlast appears on beat 16 with tkeep 0xF0.
- Inputs 0..3 each send two 16-beat packets to output 0. Required response:
  - Output 0 carries packets in source order 0,1,2,3,0,1,2,3.
  - There is exactly one idle cycle between packets.
  - Losing inputs show s_tready=0 while waiting.
- Single stream 0→2 with m_tready[2] toggling 1,0,1,0. Required response:
  - All 16 beats arrive once, in order.
  - s_tready[0] tracks the output register occupancy.
  - Output 2 never drops or duplicates a beat.
- Input 1 sends 16 beats with tdest=5. Required response:
  - s_tready[1] stays 1 for all beats.
  - No m_tvalid on any output.
  - o_drop[1] pulses for exactly 1 cycle after the tlast beat.
- Input 0 pauses tvalid for 3 cycles mid-packet to output 3 while input 2 requests output 3. Required response:
  - Input 2 is not granted until input 0's tlast.
  - Output 3 has no interleaved beats.
- i_rst_n=0 for 1 cycle during beat 8 of a 0→1 packet. Required response:
  - The next cycle all m_tvalid=0 and all s_tready=0.
  - A fresh packet sent afterwards is delivered with 2-cycle latency.
